// File: rtl/grid_pkg.sv
// grid_pkg: shared definitions for the grid front-end and cell array.
//   GRID_N            grid dimension (switch bus and select width)
//   DEBOUNCE_DEFAULT  stable samples needed before a button level is accepted
//   db_state_t        button debouncer FSM states
package grid_pkg;

  localparam int unsigned GRID_N           = 4;
  localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM_PRESS,
    PRESSED,
    CONFIRM_RELEASE
  } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, press/release debouncer FSM and a
// one-cycle press strobe for a single raw button.
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   btn    in   raw button level, active high
//   press  out  combinational strobe, high in the cycle the press is confirmed
// The strobe is combinational so the consumer's output register is the only
// register stage after the counter.
module btn_debounce
  import grid_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  db_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  assign level = sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], btn};
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    press    = 1'b0;
    case (state)
      IDLE: begin
        if (level) begin
          state_nx = CONFIRM_PRESS;
          cnt_nx   = '0;
        end
      end
      CONFIRM_PRESS: begin
        if (!level) begin
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nx = PRESSED;
          press    = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!level) begin
          state_nx = CONFIRM_RELEASE;
          cnt_nx   = '0;
        end
      end
      CONFIRM_RELEASE: begin
        // A bounce back high returns to PRESSED silently: releases never strobe.
        if (level) begin
          state_nx = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/player_input_ctrl.sv
// player_input_ctrl: board input front-end for the 4x4 grid cell array.
// Synchronizes switches, debounces buttons, latches one-hot row/column
// selections and emits single-cycle fire/add commands only when both a row
// and a column are selected.
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   sw         in   raw row/column select switches, exactly one up is valid
//   n_row      in   raw mode switch: 0 = sw loads row, 1 = sw loads column
//   btn_fire   in   raw fire button
//   btn_addn   in   raw add-ship button
//   row_sel    out  latched one-hot row enable (0 = none)
//   col_sel    out  latched one-hot column enable (0 = none)
//   sel_error  out  high while synchronized sw is not one-hot
//   fire_pulse out  one-cycle fire command
//   addn_pulse out  one-cycle add command
//   cmd_reject out  one-cycle strobe for a dropped command
module player_input_ctrl
  import grid_pkg::DEBOUNCE_DEFAULT;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned GRID_N          = grid_pkg::GRID_N
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GRID_N-1:0] sw,
  input  logic              n_row,
  input  logic              btn_fire,
  input  logic              btn_addn,
  output logic [GRID_N-1:0] row_sel,
  output logic [GRID_N-1:0] col_sel,
  output logic              sel_error,
  output logic              fire_pulse,
  output logic              addn_pulse,
  output logic              cmd_reject
);

  logic [GRID_N-1:0] sw_s1, sw_sync;
  logic              n_row_s1, n_row_sync;
  logic              fire_press, addn_press;
  int unsigned       ones;
  logic              onehot;
  logic              full_sel;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fire_db (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_fire),
    .press (fire_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_addn_db (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_addn),
    .press (addn_press)
  );

  always_comb begin
    ones = 0;
    for (int unsigned i = 0; i < GRID_N; i++) begin
      ones = ones + 32'(sw_sync[i]);
    end
    onehot = (ones == 1);
  end

  // Gating looks at the selections currently held in the registers.
  assign full_sel = (|row_sel) && (|col_sel);

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1      <= '0;
      sw_sync    <= '0;
      n_row_s1   <= 1'b0;
      n_row_sync <= 1'b0;
      row_sel    <= '0;
      col_sel    <= '0;
      sel_error  <= 1'b0;
      fire_pulse <= 1'b0;
      addn_pulse <= 1'b0;
      cmd_reject <= 1'b0;
    end else begin
      sw_s1      <= sw;
      sw_sync    <= sw_s1;
      n_row_s1   <= n_row;
      n_row_sync <= n_row_s1;

      sel_error <= !onehot;
      if (onehot) begin
        if (n_row_sync) col_sel <= sw_sync;
        else            row_sel <= sw_sync;
      end

      // Fire has priority; a simultaneous add is dropped and reported.
      fire_pulse <= fire_press && full_sel;
      addn_pulse <= addn_press && full_sel && !fire_press;
      cmd_reject <= (fire_press && !full_sel) ||
                    (addn_press && (!full_sel || fire_press));
    end
  end

endmodule

// File: tb/tb_player_input_ctrl.sv
module tb_player_input_ctrl;

  localparam int unsigned DB  = 4;
  localparam int unsigned N   = 4;
  localparam int unsigned LAT = DB + 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] sw;
  logic         n_row;
  logic         btn_fire;
  logic         btn_addn;
  logic [N-1:0] row_sel;
  logic [N-1:0] col_sel;
  logic         sel_error;
  logic         fire_pulse;
  logic         addn_pulse;
  logic         cmd_reject;

  always #5 clk = ~clk;

  player_input_ctrl #(.DEBOUNCE_CYCLES(DB), .GRID_N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .n_row      (n_row),
    .btn_fire   (btn_fire),
    .btn_addn   (btn_addn),
    .row_sel    (row_sel),
    .col_sel    (col_sel),
    .sel_error  (sel_error),
    .fire_pulse (fire_pulse),
    .addn_pulse (addn_pulse),
    .cmd_reject (cmd_reject)
  );

  // Expected command strobes: {fire_pulse, addn_pulse, cmd_reject} due at cycle.
  typedef struct {
    int unsigned due;
    logic [2:0]  pulses;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_checks = 0;
  logic [2:0]  mon_obs;
  exp_t        mon_e;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: every nonzero strobe must match the head of the scoreboard
  // on exactly its due cycle; anything else is unexpected.
  always @(negedge clk) begin
    mon_obs = {fire_pulse, addn_pulse, cmd_reject};
    if (sb.size() != 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      check("pulse", 32'(mon_obs), 32'(mon_e.pulses));
    end else if (sb.size() != 0 && sb[0].due < cyc) begin
      mon_e = sb.pop_front();
      check("missed", 32'(mon_obs), 32'(mon_e.pulses));
    end else if (mon_obs != 3'b000) begin
      check("unexpected", 32'(mon_obs), 0);
    end
  end

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic expect_cmd(input logic [2:0] p);
    exp_t e;
    e.due    = cyc + LAT;
    e.pulses = p;
    sb.push_back(e);
  endtask

  initial begin
    reset    = 1'b1;
    sw       = '0;
    n_row    = 1'b0;
    btn_fire = 1'b0;
    btn_addn = 1'b0;
    cycles(3);
    check("rst_row", 32'(row_sel), 0);
    check("rst_col", 32'(col_sel), 0);
    check("rst_err", 32'(sel_error), 0);
    check("rst_fire", 32'(fire_pulse), 0);
    check("rst_addn", 32'(addn_pulse), 0);
    check("rst_rej", 32'(cmd_reject), 0);
    reset = 1'b0;
    cycles(1);

    // Row select 0100, visible on the third edge.
    sw = 4'b0100;
    cycles(2);
    check("row_lat2", 32'(row_sel), 0);
    cycles(1);
    check("row_0100", 32'(row_sel), 32'h4);
    check("row_err", 32'(sel_error), 0);
    check("row_col", 32'(col_sel), 0);

    // Two switches up: error, selections hold.
    sw = 4'b0110;
    cycles(2);
    check("err_lat2", 32'(sel_error), 0);
    cycles(1);
    check("err_set", 32'(sel_error), 1);
    check("err_row", 32'(row_sel), 32'h4);
    check("err_col", 32'(col_sel), 0);

    // Row 0001, no column: add is rejected.
    sw = 4'b0001;
    cycles(4);
    check("row_0001", 32'(row_sel), 32'h1);
    btn_addn = 1'b1;
    expect_cmd(3'b001);
    cycles(10);
    btn_addn = 1'b0;
    cycles(12);

    // Column 1000.
    sw    = 4'b1000;
    n_row = 1'b1;
    cycles(4);
    check("col_1000", 32'(col_sel), 32'h8);
    check("col_row", 32'(row_sel), 32'h1);

    // Fire held 20 cycles: one pulse at edge 7, none on release.
    btn_fire = 1'b1;
    expect_cmd(3'b100);
    cycles(20);
    btn_fire = 1'b0;
    cycles(15);

    // Short glitch: no pulse.
    btn_fire = 1'b1;
    cycles(3);
    btn_fire = 1'b0;
    cycles(15);

    // Fire and add together: fire wins, add reported as rejected.
    btn_fire = 1'b1;
    btn_addn = 1'b1;
    expect_cmd(3'b101);
    cycles(12);
    btn_fire = 1'b0;
    btn_addn = 1'b0;
    cycles(15);

    // No switch up: error, selections hold.
    sw = 4'b0000;
    cycles(3);
    check("zero_err", 32'(sel_error), 1);
    check("zero_row", 32'(row_sel), 32'h1);
    check("zero_col", 32'(col_sel), 32'h8);

    // Reset during CONFIRM_PRESS: pending press discarded.
    sw    = 4'b0010;
    n_row = 1'b0;
    btn_fire = 1'b1;
    cycles(4);
    reset = 1'b1;
    cycles(2);
    check("mid_rst_col", 32'(col_sel), 0);
    btn_fire = 1'b0;
    reset    = 1'b0;
    cycles(15);

    // Button held through reset release: one strobe after a full debounce;
    // only a row is selected, so it is rejected.
    btn_fire = 1'b1;
    reset    = 1'b1;
    cycles(3);
    reset = 1'b0;
    expect_cmd(3'b001);
    cycles(20);
    btn_fire = 1'b0;
    cycles(15);
    check("held_row", 32'(row_sel), 32'h2);
    check("held_col", 32'(col_sel), 0);

    check("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
